spi_slave_multich: RTL and testbench



---
 rtl/spi_slave_multich.sv | 178 +++++++++++++++++
 tb/tb_spi_slave_multich.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_multich.sv
// Multi-channel SPI slave: per-channel rx word, strobe and toggle, sticky short/multi-select errors.
// Optional SPI_PARITY_EN appends an even-parity bit to every frame in both directions.
module spi_slave_multich #(
  parameter int N_CH      = 2,
  parameter int FRAME_W   = 16,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                    sclk,
  input  logic                    reset,
  input  logic                    mosi,
  input  logic [N_CH-1:0]         csel,
  output logic                    miso,
  input  logic [N_CH*FRAME_W-1:0] tx_data,
  output logic [N_CH*FRAME_W-1:0] rx_data,
  output logic [N_CH-1:0]         rx_strobe,
  output logic [N_CH-1:0]         rx_toggle,
  output logic                    short_frame,
  output logic                    multi_sel,
  output logic                    parity_err,
  input  logic                    err_clr
);
`ifdef SPI_PARITY_EN
  localparam int F = FRAME_W + 1;
`else
  localparam int F = FRAME_W;
`endif
  localparam int CW = $clog2(F + 1);
  localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(F - 1);

  logic [CW-1:0]           cnt_q, cnt_d, ec;
  logic [FRAME_W-1:0]      rx_shift_q, rx_shift_d, rx_next;
  logic [FRAME_W-1:0]      tx_shift_q, tx_shift_d, tx_word;
  logic [AW-1:0]           act_q, act_d, sel_idx;
  logic                    miso_q, miso_d;
  logic [N_CH*FRAME_W-1:0] rx_data_q, rx_data_d;
  logic [N_CH-1:0]         rx_strobe_q, rx_strobe_d, rx_toggle_q, rx_toggle_d;
  logic                    short_q, short_d, multi_q, multi_d;
  logic                    err_short, err_multi;
  logic [3:0]              n_sel;
`ifdef SPI_PARITY_EN
  logic                    tx_par_q, tx_par_d, par_q, par_d, err_par;
`endif

  always_comb begin
    n_sel   = '0;
    sel_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (csel[i]) begin
        n_sel   = n_sel + 4'd1;
        sel_idx = AW'(i);
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    act_d       = act_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_strobe_d = '0;
    rx_toggle_d = rx_toggle_q;
    err_short   = 1'b0;
    err_multi   = 1'b0;
    ec          = cnt_q;
    tx_word     = tx_data[int'(sel_idx)*FRAME_W +: FRAME_W];
    rx_next     = LSB_FIRST ? {mosi, rx_shift_q[FRAME_W-1:1]} : {rx_shift_q[FRAME_W-2:0], mosi};
`ifdef SPI_PARITY_EN
    tx_par_d    = tx_par_q;
    err_par     = 1'b0;
`endif
    if (n_sel == 4'd1) begin
      // a different channel mid-frame abandons the old frame and starts fresh here
      if (cnt_q != '0 && sel_idx != act_q) begin
        err_short = 1'b1;
        ec        = '0;
      end
      act_d = sel_idx;
      if (ec == '0) begin
        miso_d     = LSB_FIRST ? tx_word[0] : tx_word[FRAME_W-1];
        tx_shift_d = LSB_FIRST ? (tx_word >> 1) : (tx_word << 1);
`ifdef SPI_PARITY_EN
        tx_par_d   = ^tx_word;
`endif
      end else begin
        miso_d     = LSB_FIRST ? tx_shift_q[0] : tx_shift_q[FRAME_W-1];
        tx_shift_d = LSB_FIRST ? (tx_shift_q >> 1) : (tx_shift_q << 1);
`ifdef SPI_PARITY_EN
        if (ec == LAST) miso_d = tx_par_q;
`endif
      end
`ifdef SPI_PARITY_EN
      // the trailing bit is parity only; data is already complete in rx_shift_q
      if (ec == LAST) begin
        if (mosi == ^rx_shift_q) begin
          rx_data_d[int'(sel_idx)*FRAME_W +: FRAME_W] = rx_shift_q;
          rx_strobe_d[sel_idx] = 1'b1;
          rx_toggle_d[sel_idx] = ~rx_toggle_q[sel_idx];
        end else begin
          err_par = 1'b1;
        end
      end else begin
        rx_shift_d = rx_next;
      end
`else
      rx_shift_d = rx_next;
      if (ec == LAST) begin
        rx_data_d[int'(sel_idx)*FRAME_W +: FRAME_W] = rx_next;
        rx_strobe_d[sel_idx] = 1'b1;
        rx_toggle_d[sel_idx] = ~rx_toggle_q[sel_idx];
      end
`endif
      cnt_d = (ec == LAST) ? '0 : ec + CW'(1);
    end else if (n_sel == 4'd0) begin
      err_short = (cnt_q != '0);
      cnt_d     = '0;
      miso_d    = 1'b0;
    end else begin
      err_multi = 1'b1;
      cnt_d     = '0;
      miso_d    = 1'b0;
    end
    short_d = (short_q & ~err_clr) | err_short;
    multi_d = (multi_q & ~err_clr) | err_multi;
`ifdef SPI_PARITY_EN
    par_d   = (par_q & ~err_clr) | err_par;
`endif
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      act_q       <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_strobe_q <= '0;
      rx_toggle_q <= '0;
      short_q     <= 1'b0;
      multi_q     <= 1'b0;
`ifdef SPI_PARITY_EN
      tx_par_q    <= 1'b0;
      par_q       <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      act_q       <= act_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_strobe_q <= rx_strobe_d;
      rx_toggle_q <= rx_toggle_d;
      short_q     <= short_d;
      multi_q     <= multi_d;
`ifdef SPI_PARITY_EN
      tx_par_q    <= tx_par_d;
      par_q       <= par_d;
`endif
    end
  end

  assign miso        = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_strobe   = rx_strobe_q;
  assign rx_toggle   = rx_toggle_q;
  assign short_frame = short_q;
  assign multi_sel   = multi_q;
`ifdef SPI_PARITY_EN
  assign parity_err  = par_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_multich.sv
// Bench for spi_slave_multich: MSB-first and LSB-first instances share one input stream,
// compared every edge against a frame-level bit-list model plus directed constant checks.
`timescale 1ns/1ps
module tb_spi_slave_multich;
  localparam int W = 8;
`ifdef SPI_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic        sclk = 1'b0, reset = 1'b1, mosi = 1'b0, err_clr = 1'b0;
  logic [1:0]  csel = 2'b00;
  logic [15:0] tx_data = 16'h0000;
  logic        miso_a, miso_b, sh_a, sh_b, mu_a, mu_b, pe_a, pe_b;
  logic [15:0] rx_a, rx_b;
  logic [1:0]  stb_a, stb_b, tgl_a, tgl_b;

  always #5 sclk = ~sclk;

  spi_slave_multich #(.N_CH(2), .FRAME_W(W), .LSB_FIRST(1'b0)) u_msb (
    .sclk(sclk), .reset(reset), .mosi(mosi), .csel(csel), .miso(miso_a),
    .tx_data(tx_data), .rx_data(rx_a), .rx_strobe(stb_a), .rx_toggle(tgl_a),
    .short_frame(sh_a), .multi_sel(mu_a), .parity_err(pe_a), .err_clr(err_clr));

  spi_slave_multich #(.N_CH(2), .FRAME_W(W), .LSB_FIRST(1'b1)) u_lsb (
    .sclk(sclk), .reset(reset), .mosi(mosi), .csel(csel), .miso(miso_b),
    .tx_data(tx_data), .rx_data(rx_b), .rx_strobe(stb_b), .rx_toggle(tgl_b),
    .short_frame(sh_b), .multi_sel(mu_b), .parity_err(pe_b), .err_clr(err_clr));

  int n_chk = 0;
  int n_fail = 0;

  // reference model: bits of the frame in flight, in arrival order
  int          m_n = 0;
  int          m_ch = 0;
  bit          m_bits[$];
  logic [7:0]  m_tx = 8'h00;
  logic [15:0] e_rx_a = 0, e_rx_b = 0;
  logic [1:0]  e_stb = 0, e_tgl = 0;
  logic        e_sh = 0, e_mu = 0, e_pe = 0, e_miso_a = 0, e_miso_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [1:0] cs, input logic m, input logic rst,
                            input logic clr, input logic [15:0] tx);
    int k, ia, ib;
    logic [7:0] wa, wb;
    bit ok;
    if (rst) begin
      m_n = 0; m_bits.delete();
      e_rx_a = 0; e_rx_b = 0; e_stb = 0; e_tgl = 0;
      e_sh = 0; e_mu = 0; e_pe = 0; e_miso_a = 0; e_miso_b = 0;
      return;
    end
    e_stb = 0;
    if (clr) begin e_sh = 0; e_mu = 0; e_pe = 0; end
    if (cs == 2'b00) begin
      if (m_n != 0) e_sh = 1;
      m_n = 0; e_miso_a = 0; e_miso_b = 0;
    end else if (cs == 2'b11) begin
      e_mu = 1; m_n = 0; e_miso_a = 0; e_miso_b = 0;
    end else begin
      k = cs[1] ? 1 : 0;
      if (m_n != 0 && k != m_ch) begin e_sh = 1; m_n = 0; end
      m_ch = k;
      if (m_n == 0) begin m_tx = tx[k*8 +: 8]; m_bits.delete(); end
      if (m_n < W) begin
        e_miso_a = m_tx[W-1-m_n];
        e_miso_b = m_tx[m_n];
      end else begin
        e_miso_a = ^m_tx;
        e_miso_b = ^m_tx;
      end
      m_bits.push_back(m);
      m_n++;
      if (m_n == F) begin
        ia = 0; ib = 0;
        for (int j = 0; j < W; j++) begin
          ia = ia * 2 + int'(m_bits[j]);
          ib = ib + (int'(m_bits[j]) << j);
        end
        wa = 8'(ia); wb = 8'(ib);
        ok = 1;
        if (F > W) ok = (m_bits[W] == ^wa);
        if (ok) begin
          e_rx_a[k*8 +: 8] = wa;
          e_rx_b[k*8 +: 8] = wb;
          e_stb[k] = 1'b1;
          e_tgl[k] = ~e_tgl[k];
        end else begin
          e_pe = 1;
        end
        m_n = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("rx_msb", rx_a, e_rx_a);
    chk("rx_lsb", rx_b, e_rx_b);
    chk("strobe_msb", stb_a, e_stb);
    chk("strobe_lsb", stb_b, e_stb);
    chk("toggle_msb", tgl_a, e_tgl);
    chk("toggle_lsb", tgl_b, e_tgl);
    chk("short", {sh_a, sh_b}, {e_sh, e_sh});
    chk("multi", {mu_a, mu_b}, {e_mu, e_mu});
    chk("parity", {pe_a, pe_b}, {e_pe, e_pe});
    chk("miso_msb", miso_a, e_miso_a);
    chk("miso_lsb", miso_b, e_miso_b);
  endtask

  task automatic step(input logic [1:0] cs, input logic m, input logic rst = 1'b0,
                      input logic clr = 1'b0);
    @(negedge sclk);
    csel = cs; mosi = m; reset = rst; err_clr = clr;
    @(posedge sclk);
    model_edge(cs, m, rst, clr, tx_data);
    #1;
    check_all();
  endtask

  task automatic send_frame(input logic [1:0] cs, input logic [7:0] w, input logic badpar = 1'b0);
    for (int i = W - 1; i >= 0; i--) step(cs, w[i]);
    if (F > W) step(cs, (^w) ^ badpar);
  endtask

  initial begin
    logic [7:0] w, seq;
    int cur;
    logic [1:0] cs;

    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    chk("reset_rx", rx_a, 16'h0000);
    chk("reset_miso", miso_a, 1'b0);

    // channel 0 receives 0xA5 while sending 0x3C
    tx_data = 16'h993C;
    w = 8'hA5;
    seq = 8'h00;
    for (int i = W - 1; i >= 0; i--) begin
      step(2'b01, w[i]);
      seq = {seq[6:0], miso_a};
    end
    if (F > W) step(2'b01, ^w);
    chk("t1_rx0", rx_a[7:0], 8'hA5);
    chk("t1_strobe0", stb_a[0], 1'b1);
    chk("t1_toggle0", tgl_a[0], 1'b1);
    chk("t1_miso_seq", seq, 8'h3C);
    step(2'b00, 1'b0);
    chk("t1_strobe_once", stb_a[0], 1'b0);

    // back-to-back frames on channel 1
    send_frame(2'b10, 8'h12);
    chk("t2_rx1_first", rx_a[15:8], 8'h12);
    send_frame(2'b10, 8'h34);
    chk("t2_rx1_second", rx_a[15:8], 8'h34);
    chk("t2_toggle1", tgl_a[1], 1'b0);
    chk("t2_no_short", sh_a, 1'b0);

    // short frame then clear
    for (int i = 0; i < 5; i++) step(2'b01, 1'b1);
    step(2'b00, 1'b0);
    chk("t3_short", sh_a, 1'b1);
    chk("t3_rx0_kept", rx_a[7:0], 8'hA5);
    step(2'b00, 1'b0, 1'b0, 1'b1);
    chk("t3_short_clr", sh_a, 1'b0);

    // multi-select mid-frame, then a clean frame
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0);
    step(2'b11, 1'b1);
    chk("t4_multi", mu_a, 1'b1);
    chk("t4_miso0", miso_a, 1'b0);
    send_frame(2'b01, 8'h5A);
    chk("t4_rx0", rx_a[7:0], 8'h5A);

    // clear and new error on the same edge: flag stays set
    step(2'b11, 1'b0, 1'b0, 1'b1);
    chk("t5_multi_clr_set", mu_a, 1'b1);
    step(2'b00, 1'b0, 1'b0, 1'b1);

    // channel change mid-frame restarts on the new channel
    for (int i = 0; i < 3; i++) step(2'b01, 1'b1);
    tx_data = 16'hC3A5;
    send_frame(2'b10, 8'h6E);
    chk("t6_short", sh_a, 1'b1);
    chk("t6_rx1", rx_a[15:8], 8'h6E);

    // frame completing while err_clr is high
    w = 8'hF0;
    for (int i = W - 1; i >= 1; i--) step(2'b01, w[i]);
    if (F > W) begin
      step(2'b01, w[0]);
      step(2'b01, ^w, 1'b0, 1'b1);
    end else begin
      step(2'b01, w[0], 1'b0, 1'b1);
    end
    chk("t7_rx0_with_clr", rx_a[7:0], 8'hF0);
    chk("t7_short_cleared", sh_a, 1'b0);

`ifdef SPI_PARITY_EN
    send_frame(2'b01, 8'h07, 1'b1);
    chk("tp_bad_par", pe_a, 1'b1);
    chk("tp_bad_nostrobe", stb_a[0], 1'b0);
    send_frame(2'b01, 8'h07, 1'b0);
    chk("tp_good_rx", rx_a[7:0], 8'h07);
    chk("tp_good_strobe", stb_a[0], 1'b1);
`endif

    // LSB-first: bits 1,0,0,0,0,0,0,0 arrive -> 0x01
    send_frame(2'b01, 8'h80);
    chk("t8_lsb_rx0", rx_b[7:0], 8'h01);
    for (int i = 0; i < 4; i++) step(2'b01, 1'b1);
    step(2'b01, 1'b1, 1'b1);
    chk("t8_reset_rx", rx_b, 16'h0000);
    chk("t8_reset_flags", {sh_b, mu_b, pe_b, stb_b, tgl_b}, 7'b0);

    // randomized traffic with tx_data changing every edge
    cur = 0;
    for (int n = 0; n < 400; n++) begin
      int r;
      tx_data = 16'($urandom);
      r = $urandom_range(0, 99);
      if (r < 8) cur = 1 - cur;
      if (r < 82) cs = (cur == 1) ? 2'b10 : 2'b01;
      else if (r < 92) cs = 2'b00;
      else cs = 2'b11;
      step(cs, 1'($urandom), ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
